// File: rtl/ll_reader.sv
// Dequeue engine for the shared-memory linked-list manager: arbitrates over non-empty lists, pops one, reads its head word.
// Optional build macro LL_READER_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ll_reader #(
    parameter int NUM_ELEMS  = 4,
    parameter int NUM_LISTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int LIST_WIDTH = $clog2(NUM_LISTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_LISTS-1:0]           empty,
    input  logic [NUM_LISTS*PTR_WIDTH-1:0] head,
    output logic [NUM_LISTS-1:0]           pop,
    output logic                           rd_en,
    output logic [PTR_WIDTH-1:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [LIST_WIDTH-1:0]          out_list
);

    logic [PTR_WIDTH-1:0]  w_head [NUM_LISTS];
    logic [NUM_LISTS-1:0]  w_req;
    logic [LIST_WIDTH-1:0] w_rr_ptr;
    logic [LIST_WIDTH-1:0] w_cand;
    logic [LIST_WIDTH-1:0] w_grant;
    logic                  w_found;
    logic                  w_fire;
    logic [2:0]            w_occ_sum;
    logic                  w_issue;

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [LIST_WIDTH-1:0] r_inflight_list;
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [LIST_WIDTH-1:0] r_fifo_list [2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LISTS; gi++) begin : g_head
            assign w_head[gi] = head[PTR_WIDTH*gi +: PTR_WIDTH];
        end
    endgenerate

    assign w_req = ~empty;

`ifdef LL_READER_STRICT_PRIO_EN
    // Scanning from 0 every cycle gives fixed lowest-index priority.
    assign w_rr_ptr = '0;
`else
    logic [LIST_WIDTH-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_grant == LIST_WIDTH'(NUM_LISTS-1)) ? '0 : w_grant + 1'b1;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // Circular scan starting at w_rr_ptr; the first requesting list wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = w_rr_ptr;
        for (int i = 0; i < NUM_LISTS; i++) begin
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
            w_cand = (w_cand == LIST_WIDTH'(NUM_LISTS-1)) ? '0 : w_cand + 1'b1;
        end
    end

    assign out_valid = (r_occ != 2'd0);
    assign w_fire    = out_valid & out_ready;
    assign w_occ_sum = {1'b0, r_occ} + {2'b00, r_inflight};
    // rst_n gating keeps the pop request quiet while the list manager is also held in reset.
    assign w_issue   = rst_n & w_found & ((w_occ_sum < 3'd2) | w_fire);

    always_comb begin
        pop     = '0;
        rd_addr = '0;
        if (w_issue) begin
            pop[w_grant] = 1'b1;
            rd_addr      = w_head[w_grant];
        end
    end

    assign rd_en = |pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_list <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_list <= w_grant;
            end
        end
    end

    // The read return lands in the FIFO the cycle after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ    <= 2'd0;
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_list[i] <= '0;
            end
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_idx] <= rd_data;
                r_fifo_list[r_wr_idx] <= r_inflight_list;
                r_wr_idx              <= ~r_wr_idx;
            end
            if (w_fire) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_fire};
        end
    end

    assign out_data = r_fifo_data[r_rd_idx];
    assign out_list = r_fifo_list[r_rd_idx];

endmodule

// File: tb/tb_ll_reader.sv
// Directed bench for ll_reader: a small list-manager model and registered-read RAM surround the DUT.
module tb_ll_reader;
    localparam int NE = 4;
    localparam int NL = 2;
    localparam int DW = 8;
    localparam int PW = 2;
    localparam int LW = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] empty;
    logic [NL*PW-1:0] head;
    logic [NL-1:0] pop;
    logic          rd_en;
    logic [PW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] out_list;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram [NE];
    logic [PW-1:0] lm_ptr [NL][4];
    logic [1:0]    lm_rd  [NL];
    logic [2:0]    lm_cnt [NL];
    logic          ld_en;
    logic          ld_clr;
    int            ld_list;
    logic [PW-1:0] ld_ptr;

    logic [1:0]    e_pop  [7];
    logic [PW-1:0] e_addr [7];
    logic          e_val  [7];
    logic [DW-1:0] e_data [7];
    logic [LW-1:0] e_list [7];

    always #5 clk = ~clk;

    ll_reader #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .head(head), .pop(pop),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_list(out_list)
    );

    // List manager: per-list pointer queues, updated at the edge after a pop or load.
    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (ld_clr) begin
                lm_rd[k]  <= 2'd0;
                lm_cnt[k] <= 3'd0;
            end else if (ld_en && ld_list == k) begin
                lm_ptr[k][lm_rd[k] + lm_cnt[k][1:0]] <= ld_ptr;
                lm_cnt[k] <= lm_cnt[k] + 3'd1;
            end else if (pop[k]) begin
                lm_rd[k]  <= lm_rd[k] + 2'd1;
                lm_cnt[k] <= lm_cnt[k] - 3'd1;
            end
        end
    end

    always_comb begin
        empty = '0;
        head  = '0;
        for (int k = 0; k < NL; k++) begin
            empty[k]          = (lm_cnt[k] == 3'd0);
            head[k*PW +: PW]  = lm_ptr[k][lm_rd[k]];
        end
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int l, input logic [PW-1:0] p);
        ld_en   = 1'b1;
        ld_list = l;
        ld_ptr  = p;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        ld_clr    = 1'b1;
        @(negedge clk);
        ld_clr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; ld_en = 1'b0; ld_clr = 1'b1; ld_list = 0; ld_ptr = '0;
        ram[0] = 8'h10; ram[1] = 8'h11; ram[2] = 8'hA5; ram[3] = 8'h21;
        repeat (2) @(negedge clk);
        ld_clr = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_list",  32'(out_list),  32'd0);
        chk("rst_pop",       32'(pop),       32'd0);
        chk("rst_rd_en",     32'(rd_en),     32'd0);
        chk("rst_rd_addr",   32'(rd_addr),   32'd0);

        // Single entry on list 1 at pointer 2; reset must still mask the pop.
        load(1, 2'd2);
        #1;
        chk("rst_pop_nonempty",  32'(pop),     32'd0);
        chk("rst_addr_nonempty", 32'(rd_addr), 32'd0);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("single_pop_t",   32'(pop),     32'h2);
        chk("single_rden_t",  32'(rd_en),   32'd1);
        chk("single_addr_t",  32'(rd_addr), 32'd2);
        @(negedge clk); #1;
        chk("single_pop_t1",   32'(pop),       32'd0);
        chk("single_valid_t1", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk("single_valid_t2", 32'(out_valid), 32'd1);
        chk("single_data_t2",  32'(out_data),  32'hA5);
        chk("single_list_t2",  32'(out_list),  32'd1);
        @(negedge clk); #1;
        chk("single_valid_t3", 32'(out_valid), 32'd0);
        chk("single_pop_t3",   32'(pop),       32'd0);

        // Fairness: two entries per list, consumer always ready.
        do_reset();
        ram[2] = 8'h20;
        load(0, 2'd0); load(0, 2'd1); load(1, 2'd2); load(1, 2'd3);
`ifdef LL_READER_STRICT_PRIO_EN
        e_pop  = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
        e_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        e_data = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h20, 8'h21, 8'h00};
        e_list = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        e_pop  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        e_addr = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0};
        e_data = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h11, 8'h21, 8'h00};
        e_list = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        e_val  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            chk($sformatf("fair_pop_c%0d", c),   32'(pop),       32'(e_pop[c]));
            chk($sformatf("fair_addr_c%0d", c),  32'(rd_addr),   32'(e_addr[c]));
            chk($sformatf("fair_valid_c%0d", c), 32'(out_valid), 32'(e_val[c]));
            if (e_val[c]) begin
                chk($sformatf("fair_data_c%0d", c), 32'(out_data), 32'(e_data[c]));
                chk($sformatf("fair_list_c%0d", c), 32'(out_list), 32'(e_list[c]));
            end
            $display("fair cycle %0d: pop=%0h rd_addr=%0d out_valid=%0b out_data=%0h out_list=%0d",
                     c, pop, rd_addr, out_valid, out_data, out_list);
            @(negedge clk);
        end

        // Backpressure: four entries on list 0, consumer stalled.
        do_reset();
        load(0, 2'd3); load(0, 2'd1); load(0, 2'd0); load(0, 2'd2);
        rst_n = 1'b1;
        #1;
        chk("bp_pop_c0",  32'(pop),     32'd1);
        chk("bp_addr_c0", 32'(rd_addr), 32'd3);
        @(negedge clk); #1;
        chk("bp_pop_c1",   32'(pop),       32'd1);
        chk("bp_addr_c1",  32'(rd_addr),   32'd1);
        chk("bp_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk("bp_pop_c2",   32'(pop),       32'd0);
        chk("bp_valid_c2", 32'(out_valid), 32'd1);
        chk("bp_data_c2",  32'(out_data),  32'h21);
        @(negedge clk); #1;
        chk("bp_pop_c3",  32'(pop),      32'd0);
        chk("bp_data_c3", 32'(out_data), 32'h21);
        chk("bp_list_c3", 32'(out_list), 32'd0);
        @(negedge clk); #1;
        chk("bp_pop_c4_stalled", 32'(pop), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_pop_c4_ready",  32'(pop),      32'd1);
        chk("bp_addr_c4_ready", 32'(rd_addr),  32'd0);
        chk("bp_data_c4",       32'(out_data), 32'h21);
        @(negedge clk); #1;
        chk("bp_data_c5",  32'(out_data), 32'h11);
        chk("bp_pop_c5",   32'(pop),      32'd1);
        chk("bp_addr_c5",  32'(rd_addr),  32'd2);
        @(negedge clk); #1;
        chk("bp_data_c6",  32'(out_data),  32'h10);
        chk("bp_valid_c6", 32'(out_valid), 32'd1);
        chk("bp_pop_c6",   32'(pop),       32'd0);
        @(negedge clk); #1;
        chk("bp_data_c7",  32'(out_data),  32'h20);
        chk("bp_valid_c7", 32'(out_valid), 32'd1);
        @(negedge clk); #1;
        chk("bp_valid_c8", 32'(out_valid), 32'd0);
        $display("backpressure: drained, out_valid=%0b", out_valid);

        // Asynchronous reset with the FIFO full.
        do_reset();
        load(0, 2'd0); load(0, 2'd1); load(0, 2'd2); load(0, 2'd3);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("ar_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_now", 32'(out_valid), 32'd0);
        chk("ar_pop_now",   32'(pop),       32'd0);
        chk("ar_rden_now",  32'(rd_en),     32'd0);
        chk("ar_data_now",  32'(out_data),  32'd0);
        @(negedge clk);
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
        rst_n  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ar_idle_pop_c%0d", c),   32'(pop),       32'd0);
            chk($sformatf("ar_idle_valid_c%0d", c), 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
